gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Iterative Euclid GCD engine sitting directly downstream of the `mod` remainder stage in the Project 3 arithmetic datapath.
- Consumes one remainder per iteration, produced by an internal restoring shift-subtract remainder datapath (one bit per clock, same algorithm class as `mod`).
- Feeds the remainder back as the next divisor until the divisor is zero.
- Wraps the loop in a start/busy/done handshake for the surrounding control unit.

Parameters:
- WIDTH, 32, operand/result width in bits
- CNT_W, 6, width of the iteration counter (saturating)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  first operand, unsigned
- b  input  WIDTH  second operand, unsigned
- busy  output  1  high from the cycle after start is accepted until DONE exits
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  gcd(a,b); held until next accepted start
- iters  output  CNT_W  Euclid iterations (remainder steps) used

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, result=0, iters=0; internal x, y, rem, shift reg and bit counter cleared. Takes effect mid-operation with no completion pulse. After release, the engine waits in IDLE.
- States: IDLE, CHECK, MOD, SWAP, DONE.
- IDLE: on a rising edge with start=1, latch x<=a, y<=b, clear iters, go CHECK. busy=1 from the next cycle.
- CHECK: if y==0, result<=x and go DONE. Otherwise load shift reg<=x, rem<=0, bitcnt<=WIDTH-1, go MOD.
- MOD: exactly WIDTH cycles, one restoring step per cycle:
  - t = {rem, shift_msb} (WIDTH+1 bits); shift reg shifts left.
  - rem <= (t >= {0,y}) ? t - y : t[WIDTH-1:0].
  - On the cycle bitcnt==0, go SWAP. rem now equals x mod y.
- SWAP: x<=y, y<=rem, iters<=iters+1 (saturate at 2^CNT_W-1), go CHECK.
- DONE: done=1 for this single cycle, busy=0 from the next cycle, go IDLE. result and iters stay stable until the next accepted start.
- Latency: counting the start-sampling edge as edge 1, done is high in the cycle following edge N = iters*(WIDTH+2)+2.
- Boundary cases:
  - start while busy: ignored, with no effect on operands.
  - start held high across DONE: re-accepted in IDLE on the following edge, giving a new operation.
  - b=0: result=a, iters=0.
  - a=0, b≠0: one iteration, result=b.
  - a=b=0: result=0, iters=0, done still pulses.
  - a<b: first iteration swaps the operands (a mod b = a), costing one extra iteration.
- Arithmetic: unsigned only. The compare uses WIDTH+1 bits so operands near 2^WIDTH-1 do not overflow.
- Operand inputs a and b are ignored except at acceptance.

Test Plan:
- a=14, b=5, start for 1 cycle → busy rises; done on edge 104; result=1, iters=3; result holds 1 for 20 further cycles.
- a=48, b=18 → result=6, iters=3, done at edge 104. a=5, b=14 → result=1, iters=4, done at edge 138.
- a=14, b=0 → result=14, iters=0, done at edge 2. a=0, b=9 → result=9, iters=1. a=0, b=0 → result=0, done pulses.
- a=32'hFFFFFFFF, b=32'hFFFFFFFE → result=1, iters=2; no overflow in the compare.
- During a 48/18 run, pulse start with a=7, b=3 → ignored; result=6. Then start a=7, b=3 after done → result=1.
- Pull reset low mid-MOD on a 14/5 run → busy, done, result, iters all 0 immediately (asynchronous). Release, start a=21, b=14 → result=7.

Source files
------------

// File: rtl/gcd_engine.sv
// Purpose: iterative Euclid GCD; each remainder comes from a 1-bit/clk restoring shift-subtract.
// Latency: done in the cycle after edge iters*(WIDTH+2)+2, counting the start-sampling edge as 1.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start, a, b         request pulse and unsigned operands (sampled only at acceptance)
//   busy, done          busy from the cycle after acceptance through DONE; done is a 1-cycle pulse
//   result, iters       gcd(a,b) and the number of remainder steps used (saturating)
module gcd_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iters
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MOD,
    SWAP,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;

  // One restoring step: bring the next dividend bit into the partial remainder.
  // The trial value is WIDTH+1 bits wide so a remainder near 2^WIDTH-1 shifted
  // left cannot wrap before the compare.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign trial = {rem, shreg[WIDTH-1]};
  assign ge    = (trial >= {1'b0, y});
  // When ge holds, trial - y < y, so the low WIDTH bits are the exact difference.
  assign diff  = trial[WIDTH-1:0] - y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      iters  <= '0;
      x      <= '0;
      y      <= '0;
      rem    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x     <= a;
            y     <= b;
            iters <= '0;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (y == '0) begin
            result <= x;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            shreg  <= x;
            rem    <= '0;
            bitcnt <= BW'(WIDTH - 1);
            state  <= MOD;
          end
        end

        MOD: begin
          rem   <= ge ? diff : trial[WIDTH-1:0];
          shreg <= shreg << 1;
          if (bitcnt == '0) begin
            state <= SWAP;
          end else begin
            bitcnt <= bitcnt - 1'b1;
          end
        end

        SWAP: begin
          // rem now holds x mod y; it becomes the next divisor.
          x <= y;
          y <= rem;
          if (iters != '1) begin
            iters <= iters + 1'b1;
          end
          state <= CHECK;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: a transaction-level model predicts busy,
// done, result and iters every cycle; directed runs pin results and done timing.
module tb_gcd_engine;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int STEP  = WIDTH + 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] iters;

  int errors;
  int checks;
  bit chk_en;

  gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .iters  (iters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain Euclid: remainder-step count and final gcd.
  function automatic void gcd_model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                    output logic [WIDTH-1:0] r, output int it);
    logic [WIDTH-1:0] p, q, t;
    p  = ia;
    q  = ib;
    it = 0;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
      it++;
    end
    r = p;
  endfunction

  // Transaction-level model: acceptance, a fixed number of edges until done,
  // one DONE cycle, then idle again.
  logic             m_busy, m_done;
  logic [WIDTH-1:0] m_result, pend_r;
  logic [CNT_W-1:0] m_iters, pend_it;
  int               m_left;

  always @(posedge clk or negedge reset) begin
    int it;
    if (!reset) begin
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = '0;
      m_iters  = '0;
      m_left   = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_done   = 1'b1;
        m_result = pend_r;
        m_iters  = pend_it;
      end
      m_left--;
    end else if (start) begin
      gcd_model(a, b, pend_r, it);
      pend_it = (it > 63) ? 6'd63 : CNT_W'(it);
      m_busy  = 1'b1;
      m_iters = '0;
      m_left  = it * STEP + 1;
    end
  end

  // Per-cycle compare against the model; iters is only meaningful when idle or at done.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("result", 64'(result), 64'(m_result));
      if (!m_busy || m_done) chk("iters", 64'(iters), 64'(m_iters));
    end
  end

  // Issue one request and wait for done; checks result, iters and the done edge.
  task automatic run(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                     input logic [WIDTH-1:0] er, input int eit, input int eedge, input string tag);
    int n;
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d edges", tag, n);
    end else begin
      chk({tag, "_result"}, 64'(result), 64'(er));
      chk({tag, "_iters"}, 64'(iters), 64'(eit));
      chk({tag, "_done_edge"}, 64'(n), 64'(eedge));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    int it;
    int ndone;
    errors = 0;
    checks = 0;
    chk_en = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    reset  = 1'b0;

    // Pin the model itself with hand-computed values.
    gcd_model(32'd14, 32'd5, r, it);
    chk("model_14_5", {r, 32'(it)}, {32'd1, 32'd3});
    gcd_model(32'd5, 32'd14, r, it);
    chk("model_5_14", {r, 32'(it)}, {32'd1, 32'd4});
    gcd_model(32'd48, 32'd18, r, it);
    chk("model_48_18", {r, 32'(it)}, {32'd6, 32'd3});
    gcd_model(32'hFFFFFFFF, 32'hFFFFFFFE, r, it);
    chk("model_max", {r, 32'(it)}, {32'd1, 32'd2});

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_iters", 64'(iters), 64'd0);
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    run(32'd14, 32'd5, 32'd1, 3, 104, "g14_5");
    repeat (20) @(negedge clk);
    chk("hold_result", 64'(result), 64'd1);

    run(32'd48, 32'd18, 32'd6, 3, 104, "g48_18");
    run(32'd5, 32'd14, 32'd1, 4, 138, "g5_14");
    run(32'd14, 32'd0, 32'd14, 0, 2, "g14_0");
    run(32'd0, 32'd9, 32'd9, 1, 36, "g0_9");
    run(32'd0, 32'd0, 32'd0, 0, 2, "g0_0");
    run(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 2, 70, "gmax");

    // Start pulsed mid-run with different operands must be ignored.
    @(negedge clk);
    a = 32'd48; b = 32'd18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    a = 32'd7; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '0; b = '0;
    it = 0;
    while (!done && it < 2000) begin
      @(negedge clk);
      it++;
    end
    chk("ignored_start_result", 64'(result), 64'd6);
    chk("ignored_start_iters", 64'(iters), 64'd3);
    run(32'd7, 32'd3, 32'd1, 2, 70, "g7_3");

    // start held high across DONE is re-accepted: two back-to-back operations.
    @(negedge clk);
    a = 32'd14; b = 32'd0; start = 1'b1;
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_start_dones", 64'(ndone), 64'd2);
    chk("held_start_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a MOD pass.
    @(negedge clk);
    a = 32'd14; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_result", 64'(result), 64'd0);
    chk("async_rst_iters", 64'(iters), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run(32'd21, 32'd14, 32'd7, 2, 70, "g21_14");

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
